huffman_decoder: RTL
====================

Name: huffman_decoder

Overview:
- Receives the serial Huffman bitstream produced by the encoder path and regenerates the original 4-bit digit stream (symbols 0-9).
- A 10-entry code table, loaded before decode, maps each symbol to its code and code length.
- Decodes exactly SYM_COUNT symbols per block, then flags completion.
- Sits at the receive end of the stream; its output feeds a checker or store that compares against the data held on the encode side.

Parameters:
- NSYM, 10: number of symbols / table entries (digits 0-9).
- SYM_W, 4: symbol width.
- MAX_LEN, 9: maximum code length in bits (NSYM-1).
- SYM_COUNT, 256: symbols per block.
- CNT_W, 9: width of the symbol counter; must hold SYM_COUNT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- tbl_wr  in  1  table write strobe; honoured only in IDLE.
- tbl_sym  in  SYM_W  table entry index; values >= NSYM are ignored.
- tbl_code  in  MAX_LEN  code, right-aligned; MSB of the code is transmitted first.
- tbl_len  in  4  code length; 0 marks the entry invalid.
- start  in  1  begin or restart decode of one block.
- bit_in  in  1  stream bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  decoder accepts a bit; combinational, equals (state==DECODE).
- sym_out  out  SYM_W  decoded symbol.
- sym_valid  out  1  single-cycle pulse; sym_out is valid.
- sym_count  out  CNT_W  number of symbols emitted in the current block.
- busy  out  1  state==DECODE.
- done  out  1  block complete; held high.
- err  out  1  no table match within MAX_LEN bits; held high.

Behaviour:
- Reset, taken on any cycle including mid-decode:
  - state=IDLE.
  - All table lengths=0.
  - acc=0, acc_len=0.
  - sym_out=0, sym_valid=0, sym_count=0, done=0, err=0.
- States: IDLE, DECODE, DONE, ERROR.
- IDLE:
  - tbl_wr writes code/len into entry tbl_sym.
  - start -> DECODE; clears acc, acc_len, sym_count, done, err.
  - bit_valid is ignored.
- DECODE, on each bit transfer (bit_valid & bit_ready):
  - acc_n = {acc[MAX_LEN-2:0], bit_in}; len_n = acc_len+1.
  - Entry i matches when tbl_len[i]==len_n, tbl_len[i]!=0, and the low len_n bits of acc_n equal the low len_n bits of tbl_code[i].
  - If several entries match, the lowest index wins.
  - On a match, next cycle: sym_out=i, sym_valid=1, acc=0, acc_len=0, sym_count+1.
  - Latency is one cycle from bit acceptance to sym_valid, so back-to-back 1-bit codes give one symbol per cycle.
  - No match and len_n==MAX_LEN -> ERROR, err=1, sym_valid=0.
  - No match otherwise -> acc=acc_n, acc_len=len_n.
- DECODE, no bit_valid: registers hold; sym_valid=0.
- Block completion: the match that brings sym_count to SYM_COUNT also sets done=1 and moves to DONE in the same edge as its sym_valid.
- DONE: bit_ready=0; extra bits are dropped. start -> DECODE (table retained).
- ERROR: bit_ready=0; start -> DECODE with state cleared as in IDLE.
- start while in DECODE restarts the block and clears state; any bit presented in that same cycle is discarded.
- tbl_wr outside IDLE is ignored. To reload the table, reset first.
- sym_valid is never asserted in the same cycle as err.
- sym_count is unsigned and does not wrap, because the transition to DONE happens at SYM_COUNT.

Decomposition:
- Shared package huffman_pkg holds the constants NSYM, SYM_W, MAX_LEN, SYM_COUNT, CNT_W and the state encoding. The encoder side reuses the same package.
- One natural sub-module, huffman_code_match: combinational parallel comparison of acc_n/len_n against all NSYM entries, returning hit and index through a priority encoder.
- The FSM, table registers and counters stay in huffman_decoder.

Test Plan:
- Load table {0:"0"/1, 1:"10"/2, 2:"110"/3, 3:"111"/3}, start, send bits 0,1,0,1,1,0,1,1,1 -> sym_out 0,1,2,3, each sym_valid one cycle after its final bit; sym_count=4.
- Same table, 256 consecutive "0" bits with bit_valid held high -> 256 sym_valid pulses, done=1 with the last pulse, bit_ready=0 the next cycle, sym_count=256.
- Table containing only entry 0="0"/1, send nine 1-bits -> err=1 after the ninth bit, no sym_valid, bit_ready=0; start then returns to DECODE with err=0.
- Gap test: bits 1 (idle 5 cycles) 0 -> a single sym_valid with sym_out=1 after the second bit; no output during the gap.
- Reset after 100 symbols -> all outputs 0 on the next cycle, table lengths 0; a later start with no reload and any 9 bits -> err=1.
- tbl_wr with tbl_sym=12, and tbl_wr during DECODE -> table unchanged; decode results identical to the first scenario.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared constants and state encoding for the Huffman encode/decode path.
//   NSYM      : number of symbols / code table entries (digits 0-9)
//   SYM_W     : symbol width
//   MAX_LEN   : longest legal code in bits
//   LEN_W     : width of a code-length field
//   SYM_COUNT : symbols per block
//   CNT_W     : width of the per-block symbol counter
package huffman_pkg;

    localparam int NSYM      = 10;
    localparam int SYM_W     = 4;
    localparam int MAX_LEN   = 9;
    localparam int LEN_W     = 4;
    localparam int SYM_COUNT = 256;
    localparam int CNT_W     = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    // Mask selecting the low 'len' bits of a MAX_LEN-wide code.
    // len == MAX_LEN shifts every one out, giving an all-ones mask.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
        return ~({MAX_LEN{1'b1}} << len);
    endfunction

endpackage

// File: rtl/huffman_code_match.sv
// Combinational parallel match of the candidate bit window against every
// code table entry, followed by a lowest-index-wins priority encoder.
// Ports:
//   acc_n    in  MAX_LEN        candidate bits, newest bit in the LSB
//   len_n    in  LEN_W          number of valid bits in acc_n
//   tbl_code in  MAX_LEN x NSYM right-aligned codes
//   tbl_len  in  LEN_W x NSYM   code lengths, 0 = entry unused
//   hit      out 1              at least one entry matches
//   idx      out SYM_W          index of the lowest matching entry
module huffman_code_match
    import huffman_pkg::*;
(
    input  logic [MAX_LEN-1:0] acc_n,
    input  logic [LEN_W-1:0]   len_n,
    input  logic [MAX_LEN-1:0] tbl_code [NSYM],
    input  logic [LEN_W-1:0]   tbl_len  [NSYM],
    output logic               hit,
    output logic [SYM_W-1:0]   idx
);

    logic [MAX_LEN-1:0] mask;
    logic [NSYM-1:0]    match_vec;

    assign mask = len_mask(len_n);

    generate
        for (genvar gi = 0; gi < NSYM; gi++) begin : g_entry
            // Lengths must agree exactly; comparing only the low len_n bits
            // means a short code never matches a prefix of a longer window.
            assign match_vec[gi] = (tbl_len[gi] != '0) &&
                                   (tbl_len[gi] == len_n) &&
                                   ((acc_n & mask) == (tbl_code[gi] & mask));
        end
    endgenerate

    assign hit = |match_vec;

    // Scan from the top down so the lowest matching index is the last write.
    always_comb begin
        idx = '0;
        for (int i = NSYM - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                idx = SYM_W'(i);
            end
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: shifts stream bits into an accumulator and emits
// a symbol whenever the accumulated bits equal a loaded table code. Decodes
// SYM_COUNT symbols per block, then holds done until the next start.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   tbl_wr/tbl_sym/      code table write (IDLE only; tbl_sym >= NSYM ignored)
//   tbl_code/tbl_len
//   start                begin/restart a block
//   bit_in, bit_valid    stream bit and its qualifier
//   bit_ready            high in DECODE (combinational)
//   sym_out, sym_valid   decoded symbol and its single-cycle strobe
//   sym_count            symbols emitted in the current block
//   busy, done, err      status; done and err are sticky until start
module huffman_decoder
    import huffman_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tbl_wr,
    input  logic [SYM_W-1:0]   tbl_sym,
    input  logic [MAX_LEN-1:0] tbl_code,
    input  logic [LEN_W-1:0]   tbl_len,
    input  logic               start,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic [SYM_W-1:0]   sym_out,
    output logic               sym_valid,
    output logic [CNT_W-1:0]   sym_count,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t state_reg, state_next;

    logic [MAX_LEN-1:0] code_reg [NSYM];
    logic [LEN_W-1:0]   len_reg  [NSYM];

    // The accumulator keeps MAX_LEN-1 bits: a window that reaches MAX_LEN
    // bits either matches or errors, so it is never stored back.
    logic [MAX_LEN-2:0] acc_reg;
    logic [LEN_W-1:0]   acc_len_reg;
    logic [SYM_W-1:0]   sym_out_reg;
    logic               sym_valid_reg;
    logic [CNT_W-1:0]   sym_count_reg;
    logic               done_reg;
    logic               err_reg;

    logic [MAX_LEN-1:0] acc_n;
    logic [LEN_W-1:0]   len_n;
    logic [CNT_W-1:0]   count_inc;
    logic               bit_xfer;
    logic               match_hit;
    logic [SYM_W-1:0]   match_idx;
    logic               last_sym;
    logic               overflow;

    assign bit_ready = (state_reg == ST_DECODE);
    assign busy      = (state_reg == ST_DECODE);

    // A start in DECODE restarts the block, so a bit offered alongside it
    // must not be consumed.
    assign bit_xfer  = bit_valid && bit_ready && !start;

    assign acc_n     = {acc_reg, bit_in};
    assign len_n     = acc_len_reg + 1'b1;
    assign count_inc = sym_count_reg + 1'b1;
    assign last_sym  = (count_inc == CNT_W'(SYM_COUNT));
    assign overflow  = (len_n == LEN_W'(MAX_LEN));

    huffman_code_match u_match (
        .acc_n    (acc_n),
        .len_n    (len_n),
        .tbl_code (code_reg),
        .tbl_len  (len_reg),
        .hit      (match_hit),
        .idx      (match_idx)
    );

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (start) begin
                    state_next = ST_DECODE;
                end else if (bit_xfer) begin
                    if (match_hit) begin
                        if (last_sym) state_next = ST_DONE;
                    end else if (overflow) begin
                        state_next = ST_ERROR;
                    end
                end
            end
            ST_DONE: begin
                if (start) state_next = ST_DECODE;
            end
            ST_ERROR: begin
                if (start) state_next = ST_DECODE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Code table: kept in flops because every entry is compared each cycle.
    generate
        for (genvar gi = 0; gi < NSYM; gi++) begin : g_table
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    code_reg[gi] <= '0;
                    len_reg[gi]  <= '0;
                end else if (tbl_wr && (state_reg == ST_IDLE) &&
                             (tbl_sym == SYM_W'(gi))) begin
                    code_reg[gi] <= tbl_code;
                    len_reg[gi]  <= tbl_len;
                end
            end
        end
    endgenerate

    // Datapath: accumulator, symbol output, counter and sticky flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg       <= '0;
            acc_len_reg   <= '0;
            sym_out_reg   <= '0;
            sym_valid_reg <= 1'b0;
            sym_count_reg <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            sym_valid_reg <= 1'b0;
            if (start) begin
                acc_reg       <= '0;
                acc_len_reg   <= '0;
                sym_count_reg <= '0;
                done_reg      <= 1'b0;
                err_reg       <= 1'b0;
            end else if (bit_xfer) begin
                if (match_hit) begin
                    sym_out_reg   <= match_idx;
                    sym_valid_reg <= 1'b1;
                    acc_reg       <= '0;
                    acc_len_reg   <= '0;
                    sym_count_reg <= count_inc;
                    if (last_sym) done_reg <= 1'b1;
                end else if (overflow) begin
                    err_reg <= 1'b1;
                end else begin
                    acc_reg     <= acc_n[MAX_LEN-2:0];
                    acc_len_reg <= len_n;
                end
            end
        end
    end

    assign sym_out   = sym_out_reg;
    assign sym_valid = sym_valid_reg;
    assign sym_count = sym_count_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule
